multicycle_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32I core datapath. It fetches each instruction over a request/acknowledge handshake and latches it into an instruction register. It then sequences decode, execute and writeback by pulsing the datapath's latch and write enables. It detects illegal encodings and keeps cycle and retired-instruction counters. It sits between the instruction memory and the existing PC, register file, ALU and control decode.

---
 rtl/cpu_ctrl_pkg.sv | 17 +
 rtl/insn_legality_check.sv | 17 +
 rtl/multicycle_sequencer.sv | 77 +++++++
 tb/tb_multicycle_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state, opcode and funct7 definitions for the RV32I control path
package cpu_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;
  typedef enum logic [6:0] {
    OP_REG = 7'b0110011,
    OP_IMM = 7'b0010011
  } opcode_t;
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
endpackage

// File: rtl/insn_legality_check.sv
// insn_legality_check: flags instruction words outside the supported OP/OP-IMM subset
module insn_legality_check
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic        legal
);
  logic [6:0] f7;
  logic [2:0] f3;
  assign f7 = ir[31:25];
  assign f3 = ir[14:12];
  // the alternate funct7 is only accepted for SUB; shift-immediates need a zero upper field
  always_comb
    legal = (ir[6:0] == OP_REG) ? (f7 == FUNCT7_BASE || (f7 == FUNCT7_ALT && f3 == 3'b000)) :
            (ir[6:0] == OP_IMM) ? ((f3 != 3'b001 && f3 != 3'b101) || f7 == FUNCT7_BASE) :
            1'b0;
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: fetch/decode/execute/writeback control FSM with IR,
// illegal-instruction detection and cycle/instret counters
module multicycle_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic HALT_ON_ILLEGAL = 1'b1,
  parameter int   CNT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  output logic                 imem_req,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          ir,
  output logic                 ir_write,
  output logic                 operand_latch,
  output logic                 alu_latch,
  output logic                 rf_write,
  output logic                 pc_write,
  output logic [2:0]           state,
  output logic                 illegal,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instret_count
);
  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  state_t                 state_q, state_d;
  logic   [31:0]          ir_q;
  logic                   illegal_q;
  logic   [CNT_WIDTH-1:0] cycle_q, instret_q;
  logic                   legal;
  insn_legality_check u_legal (
    .ir   (ir_q),
    .legal(legal)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = run ? S_FETCH : S_IDLE;
      S_FETCH:     state_d = imem_ack ? S_DECODE : S_FETCH;
      S_DECODE:    state_d = legal ? S_EXECUTE : HALT_ON_ILLEGAL ? S_HALT : run ? S_FETCH : S_IDLE;
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = run ? S_FETCH : S_IDLE;
      default:     state_d = S_HALT;
    endcase
  end
  always_comb begin
    imem_req      = state_q == S_FETCH;
    ir_write      = imem_req && imem_ack;
    operand_latch = state_q == S_DECODE;
    alu_latch     = state_q == S_EXECUTE;
    rf_write      = state_q == S_WRITEBACK && ir_q[11:7] != 5'd0;
    pc_write      = state_q == S_WRITEBACK || (operand_latch && !legal && !HALT_ON_ILLEGAL);
    halted        = state_q == S_HALT;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ir_q      <= '0;
      illegal_q <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (ir_write) ir_q <= imem_rdata;
      if (operand_latch && !legal) illegal_q <= 1'b1;
      if (state_q != S_IDLE && state_q != S_HALT) cycle_q <= cycle_q + ONE;
      if (state_q == S_WRITEBACK) instret_q <= instret_q + ONE;
    end
  assign ir            = ir_q;
  assign state         = state_q;
  assign illegal       = illegal_q;
  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed bench over three parameterisations with a retirement scoreboard
module tb_multicycle_sequencer;
  import cpu_ctrl_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n[3], run[3], ack[3];
  logic [31:0] rdata[3];
  logic        req[3], irw[3], opl[3], alul[3], rfw[3], pcw[3], ill[3], hlt[3];
  logic [2:0]  st[3];
  logic [31:0] ir[3];
  logic [31:0] cyc0, ret0, cyc1, ret1;
  logic [3:0]  cyc2, ret2;
  typedef struct {
    int          idx;
    logic [31:0] word;
    logic        rf;
    logic [2:0]  st;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0;
  int rf_pulses[3] = '{0, 0, 0};
  int pc_pulses[3] = '{0, 0, 0};

  multicycle_sequencer u0 (
    .clk(clk), .reset_n(rst_n[0]), .run(run[0]), .imem_req(req[0]), .imem_ack(ack[0]),
    .imem_rdata(rdata[0]), .ir(ir[0]), .ir_write(irw[0]), .operand_latch(opl[0]),
    .alu_latch(alul[0]), .rf_write(rfw[0]), .pc_write(pcw[0]), .state(st[0]),
    .illegal(ill[0]), .halted(hlt[0]), .cycle_count(cyc0), .instret_count(ret0)
  );
  multicycle_sequencer #(.HALT_ON_ILLEGAL(1'b0)) u1 (
    .clk(clk), .reset_n(rst_n[1]), .run(run[1]), .imem_req(req[1]), .imem_ack(ack[1]),
    .imem_rdata(rdata[1]), .ir(ir[1]), .ir_write(irw[1]), .operand_latch(opl[1]),
    .alu_latch(alul[1]), .rf_write(rfw[1]), .pc_write(pcw[1]), .state(st[1]),
    .illegal(ill[1]), .halted(hlt[1]), .cycle_count(cyc1), .instret_count(ret1)
  );
  multicycle_sequencer #(.CNT_WIDTH(4)) u2 (
    .clk(clk), .reset_n(rst_n[2]), .run(run[2]), .imem_req(req[2]), .imem_ack(ack[2]),
    .imem_rdata(rdata[2]), .ir(ir[2]), .ir_write(irw[2]), .operand_latch(opl[2]),
    .alu_latch(alul[2]), .rf_write(rfw[2]), .pc_write(pcw[2]), .state(st[2]),
    .illegal(ill[2]), .halted(hlt[2]), .cycle_count(cyc2), .instret_count(ret2)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // every pc_write pulse is a retirement (or a skipped illegal) and must match the next queued entry
  always @(negedge clk)
    for (int i = 0; i < 3; i++)
      if (rst_n[i] === 1'b1) begin
        if (rfw[i] === 1'b1) rf_pulses[i]++;
        if (pcw[i] === 1'b1) begin
          pc_pulses[i]++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_underflow: unexpected pc_write on instance %0d, ir %0h", i, ir[i]);
          end else begin
            mon_e = sb.pop_front();
            check("sb_idx", i, mon_e.idx);
            check("sb_ir", ir[i], mon_e.word);
            check("sb_rf_write", {31'b0, rfw[i]}, {31'b0, mon_e.rf});
            check("sb_state", {29'b0, st[i]}, {29'b0, mon_e.st});
          end
        end
      end

  task automatic fetch(int i, logic [31:0] w, int waits, logic rf_exp, logic [2:0] st_exp, bit push);
    int n = 0;
    while (req[i] !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (req[i] !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL fetch_timeout: imem_req observed %b required 1 on instance %0d", req[i], i);
      return;
    end
    repeat (waits) step();
    if (push) sb.push_back('{i, w, rf_exp, st_exp});
    ack[i]   = 1'b1;
    rdata[i] = w;
    #1 check("ir_write", {31'b0, irw[i]}, 32'd1);
    step();
    ack[i]   = 1'b0;
    rdata[i] = 32'hdeadbeef;
  endtask

  task automatic wait_state(int i, logic [2:0] s);
    int n = 0;
    while (st[i] !== s && n < 50) begin
      step();
      n++;
    end
    check("wait_state", {29'b0, st[i]}, {29'b0, s});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (rst_n[i]) begin
      rst_n[i] = 1'b0;
      run[i]   = 1'b0;
      ack[i]   = 1'b0;
      rdata[i] = '0;
    end
    repeat (2) step();
    check("rst_state", {29'b0, st[0]}, S_IDLE);
    check("rst_ir", ir[0], 32'd0);
    check("rst_outputs", {26'b0, req[0], irw[0], opl[0], alul[0], rfw[0], pcw[0]}, 32'd0);
    check("rst_flags", {30'b0, ill[0], hlt[0]}, 32'd0);
    check("rst_cycle", cyc0, 32'd0);
    check("rst_instret", ret0, 32'd0);
    foreach (rst_n[i]) rst_n[i] = 1'b1;
    step();
    // three legal instructions, one wait cycle each, run dropped during the last EXECUTE
    run[0] = 1'b1;
    fetch(0, 32'h005303B3, 1, 1'b1, S_WRITEBACK, 1'b1);
    fetch(0, 32'h40848533, 1, 1'b1, S_WRITEBACK, 1'b1);
    fetch(0, 32'h00160693, 1, 1'b1, S_WRITEBACK, 1'b1);
    check("decode_latch", {30'b0, opl[0], alul[0]}, 32'd2);
    step();
    check("exec_state", {29'b0, st[0]}, S_EXECUTE);
    check("exec_latch", {30'b0, opl[0], alul[0]}, 32'd1);
    run[0] = 1'b0;
    wait_state(0, S_IDLE);
    check("seq_cycle", cyc0, 32'd15);
    check("seq_instret", ret0, 32'd3);
    check("seq_ir", ir[0], 32'h00160693);
    check("seq_rf_pulses", rf_pulses[0], 32'd3);
    check("seq_pc_pulses", pc_pulses[0], 32'd3);
    ack[0] = 1'b1;
    repeat (5) step();
    ack[0] = 1'b0;
    check("idle_frozen_cycle", cyc0, 32'd15);
    check("idle_ir_unchanged", ir[0], 32'h00160693);
    // add x0,x0,x0 retires without a register write
    run[0] = 1'b1;
    fetch(0, 32'h00000033, 0, 1'b0, S_WRITEBACK, 1'b1);
    step();
    run[0] = 1'b0;
    wait_state(0, S_IDLE);
    check("x0_instret", ret0, 32'd4);
    check("x0_cycle", cyc0, 32'd19);
    check("x0_rf_pulses", rf_pulses[0], 32'd3);
    check("x0_pc_pulses", pc_pulses[0], 32'd4);
    // illegal all-zero word parks in HALT
    run[0] = 1'b1;
    fetch(0, 32'h00000000, 0, 1'b0, S_HALT, 1'b0);
    check("ill_decode_pc", {31'b0, pcw[0]}, 32'd0);
    step();
    check("ill_flags", {30'b0, ill[0], hlt[0]}, 32'd3);
    ack[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check("halt_state", {29'b0, st[0]}, S_HALT);
      check("halt_outputs", {26'b0, req[0], irw[0], opl[0], alul[0], rfw[0], pcw[0]}, 32'd0);
      step();
    end
    ack[0] = 1'b0;
    check("halt_instret", ret0, 32'd4);
    check("halt_cycle", cyc0, 32'd21);
    // async reset drops imem_req mid-FETCH and aborts an instruction in WRITEBACK
    rst_n[0] = 1'b0;
    run[0]   = 1'b0;
    step();
    rst_n[0] = 1'b1;
    run[0]   = 1'b1;
    step();
    check("pre_reset_req", {31'b0, req[0]}, 32'd1);
    rst_n[0] = 1'b0;
    #1 check("async_req_drop", {31'b0, req[0]}, 32'd0);
    check("async_state", {29'b0, st[0]}, S_IDLE);
    step();
    rst_n[0] = 1'b1;
    fetch(0, 32'h005303B3, 0, 1'b1, S_WRITEBACK, 1'b0);
    step();
    step();
    check("wb_state", {29'b0, st[0]}, S_WRITEBACK);
    rst_n[0] = 1'b0;
    run[0]   = 1'b0;
    #1 check("wb_reset_req", {31'b0, req[0]}, 32'd0);
    step();
    step();
    rst_n[0] = 1'b1;
    step();
    check("post_reset_state", {29'b0, st[0]}, S_IDLE);
    check("post_reset_instret", ret0, 32'd0);
    check("post_reset_cycle", cyc0, 32'd0);
    check("post_reset_ir", ir[0], 32'd0);
    // HALT_ON_ILLEGAL=0 skips the illegal word with a PC bump in DECODE
    run[1] = 1'b1;
    fetch(1, 32'h00000000, 0, 1'b0, S_DECODE, 1'b1);
    check("skip_strobes", {29'b0, opl[1], rfw[1], pcw[1]}, 32'd5);
    run[1] = 1'b0;
    step();
    check("skip_state", {29'b0, st[1]}, S_IDLE);
    check("skip_flags", {30'b0, ill[1], hlt[1]}, 32'd2);
    check("skip_instret", ret1, 32'd0);
    check("skip_cycle", cyc1, 32'd2);
    run[1] = 1'b1;
    fetch(1, 32'h00160693, 0, 1'b1, S_WRITEBACK, 1'b1);
    step();
    run[1] = 1'b0;
    wait_state(1, S_IDLE);
    check("skip_then_retire", ret1, 32'd1);
    check("skip_sticky", {31'b0, ill[1]}, 32'd1);
    // 4-bit counters wrap after 16 back-to-back retirements
    run[2] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      fetch(2, 32'h00160693, 0, 1'b1, S_WRITEBACK, 1'b1);
      check("wrap_progress", {28'b0, ret2}, 32'((k - 1) % 16));
    end
    step();
    run[2] = 1'b0;
    wait_state(2, S_IDLE);
    check("wrap_instret", {28'b0, ret2}, 32'd0);
    check("wrap_cycle", {28'b0, cyc2}, 32'd0);
    check("wrap_pc_pulses", pc_pulses[2], 32'd16);
    repeat (2) step();
    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
